// File: rtl/scr_memif_to_mem.sv
// SCR1 memory port to mem_valid/mem_ready bus adapter: one request at a time, RDY/ER pulse on the cycle after mem_ready.
// Requester is held off (scr_req_ack_o low) until the response; optional BUSY watchdog under `SCR_MEMIF_TIMEOUT_EN.
module scr_memif_to_mem #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        scr_req_i,
  output logic        scr_req_ack_o,
  input  logic        scr_cmd_i,
  input  logic [1:0]  scr_width_i,
  input  logic [31:0] scr_addr_i,
  input  logic [31:0] scr_wdata_i,
  output logic [31:0] scr_rdata_o,
  output logic [1:0]  scr_resp_o,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] RESP_IDLE = 2'd0;
  localparam logic [1:0] RESP_RDY  = 2'd1;
  localparam logic [1:0] RESP_ER   = 2'd2;

  state_t      state;
  logic        illegal;
  logic [3:0]  strb;
  logic [31:0] wdata_lane;

`ifdef SCR_MEMIF_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] tmo_cnt;
  logic            tmo_hit;
  // Expiry on the edge that closes the TIMEOUT_CYCLES-th BUSY cycle.
  assign tmo_hit = (tmo_cnt == CntW'(TIMEOUT_CYCLES - 1));
`endif

  assign scr_req_ack_o = (state == IDLE);

  // Alignment check, lane strobes and replicated write data for the incoming request.
  always_comb begin
    illegal    = 1'b0;
    strb       = 4'b0000;
    wdata_lane = scr_wdata_i;
    case (scr_width_i)
      2'd0: begin
        strb       = 4'b0001 << scr_addr_i[1:0];
        wdata_lane = {4{scr_wdata_i[7:0]}};
      end
      2'd1: begin
        illegal    = scr_addr_i[0];
        strb       = 4'b0011 << scr_addr_i[1:0];
        wdata_lane = {2{scr_wdata_i[15:0]}};
      end
      2'd2: begin
        illegal = |scr_addr_i[1:0];
        strb    = 4'b1111;
      end
      default: illegal = 1'b1;
    endcase
    if (!scr_cmd_i) begin
      strb = 4'b0000;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state       <= IDLE;
      mem_valid   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wstrb   <= '0;
      scr_resp_o  <= RESP_IDLE;
      scr_rdata_o <= '0;
`ifdef SCR_MEMIF_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          scr_resp_o <= RESP_IDLE;
          if (scr_req_i) begin
            if (illegal) begin
              scr_resp_o <= RESP_ER;
              state      <= RESP;
            end else begin
              mem_addr  <= {scr_addr_i[31:2], 2'b00};
              mem_wdata <= wdata_lane;
              mem_wstrb <= strb;
              mem_valid <= 1'b1;
              state     <= BUSY;
`ifdef SCR_MEMIF_TIMEOUT_EN
              tmo_cnt   <= '0;
`endif
            end
          end
        end
        BUSY: begin
          // mem_valid must fall on the ready edge or the master starts a second transfer.
          if (mem_ready) begin
            mem_valid   <= 1'b0;
            scr_rdata_o <= mem_rdata;
            scr_resp_o  <= RESP_RDY;
            state       <= RESP;
`ifdef SCR_MEMIF_TIMEOUT_EN
          end else if (tmo_hit) begin
            mem_valid  <= 1'b0;
            scr_resp_o <= RESP_ER;
            state      <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
`endif
          end
        end
        RESP: begin
          scr_resp_o <= RESP_IDLE;
          state      <= IDLE;
        end
        default: begin
          mem_valid  <= 1'b0;
          scr_resp_o <= RESP_IDLE;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scr_memif_to_mem.sv
module tb_scr_memif_to_mem;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_n_i;
  logic        scr_req_i;
  logic        scr_req_ack_o;
  logic        scr_cmd_i;
  logic [1:0]  scr_width_i;
  logic [31:0] scr_addr_i;
  logic [31:0] scr_wdata_i;
  logic [31:0] scr_rdata_o;
  logic [1:0]  scr_resp_o;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  int valid_rises = 0;

  scr_memif_to_mem dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_n_i    (wb_rst_n_i),
    .scr_req_i     (scr_req_i),
    .scr_req_ack_o (scr_req_ack_o),
    .scr_cmd_i     (scr_cmd_i),
    .scr_width_i   (scr_width_i),
    .scr_addr_i    (scr_addr_i),
    .scr_wdata_i   (scr_wdata_i),
    .scr_rdata_o   (scr_rdata_o),
    .scr_resp_o    (scr_resp_o),
    .mem_valid     (mem_valid),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  always @(posedge mem_valid) valid_rises++;

  // Present a request for one accept edge; returns #1 after that edge.
  task automatic start_req(input logic cmd, input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
    scr_req_i   = 1'b1;
    scr_cmd_i   = cmd;
    scr_width_i = w;
    scr_addr_i  = a;
    scr_wdata_i = d;
    @(posedge wb_clk_i); #1;
    scr_req_i = 1'b0;
  endtask

  // One-cycle completion pulse from the bus; returns #1 after the ready edge.
  task automatic pulse_ready(input logic [31:0] r);
    mem_ready = 1'b1;
    mem_rdata = r;
    @(posedge wb_clk_i); #1;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
  endtask

  task automatic test_reset;
    wb_rst_n_i = 1'b0;
    scr_req_i = 1'b0; scr_cmd_i = 1'b0; scr_width_i = 2'd0;
    scr_addr_i = 32'h0; scr_wdata_i = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
    #22;
    n_cmp++; if (mem_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %h want 0", mem_valid); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_addr got %h want 0", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_wdata got %h want 0", mem_wdata); end
    n_cmp++; if (mem_wstrb !== 4'h0) begin n_bad++; $display("FAIL rst_wstrb got %h want 0", mem_wstrb); end
    n_cmp++; if (scr_resp_o !== 2'd0) begin n_bad++; $display("FAIL rst_resp got %0d want 0", scr_resp_o); end
    n_cmp++; if (scr_rdata_o !== 32'h0) begin n_bad++; $display("FAIL rst_rdata got %h want 0", scr_rdata_o); end
    n_cmp++; if (scr_req_ack_o !== 1'b1) begin n_bad++; $display("FAIL rst_ack got %b want 1", scr_req_ack_o); end
    @(negedge wb_clk_i);
    wb_rst_n_i = 1'b1;
    @(posedge wb_clk_i); #1;
  endtask

  task automatic test_word_write;
    start_req(1'b1, 2'd2, 32'h0000_0100, 32'hDEAD_BEEF);
    n_cmp++; if (mem_valid !== 1'b1) begin n_bad++; $display("FAIL ww_valid got %b want 1", mem_valid); end
    n_cmp++; if (mem_addr !== 32'h100) begin n_bad++; $display("FAIL ww_addr got %h want 00000100", mem_addr); end
    n_cmp++; if (mem_wstrb !== 4'b1111) begin n_bad++; $display("FAIL ww_wstrb got %b want 1111", mem_wstrb); end
    n_cmp++; if (mem_wdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL ww_wdata got %h want deadbeef", mem_wdata); end
    n_cmp++; if (scr_req_ack_o !== 1'b0) begin n_bad++; $display("FAIL ww_ack_busy got %b want 0", scr_req_ack_o); end
    for (int i = 0; i < 2; i++) begin
      @(posedge wb_clk_i); #1;
      n_cmp++; if (mem_valid !== 1'b1 || scr_resp_o !== 2'd0)
        begin n_bad++; $display("FAIL ww_hold valid=%b resp=%0d want valid=1 resp=0", mem_valid, scr_resp_o); end
    end
    pulse_ready(32'hCAFE_F00D);
    n_cmp++; if (mem_valid !== 1'b0) begin n_bad++; $display("FAIL ww_drop got %b want 0", mem_valid); end
    n_cmp++; if (scr_resp_o !== 2'd1) begin n_bad++; $display("FAIL ww_rdy got %0d want 1", scr_resp_o); end
    n_cmp++; if (scr_rdata_o !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL ww_rdata got %h want cafef00d", scr_rdata_o); end
    n_cmp++; if (scr_req_ack_o !== 1'b0) begin n_bad++; $display("FAIL ww_ack_resp got %b want 0", scr_req_ack_o); end
    @(posedge wb_clk_i); #1;
    n_cmp++; if (scr_resp_o !== 2'd0) begin n_bad++; $display("FAIL ww_pulse got %0d want 0", scr_resp_o); end
    n_cmp++; if (scr_req_ack_o !== 1'b1) begin n_bad++; $display("FAIL ww_ack_idle got %b want 1", scr_req_ack_o); end
  endtask

  task automatic test_byte_half_write;
    start_req(1'b1, 2'd0, 32'h0000_0203, 32'h0000_00A5);
    n_cmp++; if (mem_addr !== 32'h200) begin n_bad++; $display("FAIL bw_addr got %h want 00000200", mem_addr); end
    n_cmp++; if (mem_wstrb !== 4'b1000) begin n_bad++; $display("FAIL bw_wstrb got %b want 1000", mem_wstrb); end
    n_cmp++; if (mem_wdata !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL bw_wdata got %h want a5a5a5a5", mem_wdata); end
    pulse_ready(32'h0);
    n_cmp++; if (scr_resp_o !== 2'd1) begin n_bad++; $display("FAIL bw_rdy got %0d want 1", scr_resp_o); end
    @(posedge wb_clk_i); #1;
    start_req(1'b1, 2'd1, 32'h0000_0202, 32'h0000_1234);
    n_cmp++; if (mem_addr !== 32'h200) begin n_bad++; $display("FAIL hw_addr got %h want 00000200", mem_addr); end
    n_cmp++; if (mem_wstrb !== 4'b1100) begin n_bad++; $display("FAIL hw_wstrb got %b want 1100", mem_wstrb); end
    n_cmp++; if (mem_wdata !== 32'h1234_1234) begin n_bad++; $display("FAIL hw_wdata got %h want 12341234", mem_wdata); end
    pulse_ready(32'h0);
    n_cmp++; if (scr_resp_o !== 2'd1) begin n_bad++; $display("FAIL hw_rdy got %0d want 1", scr_resp_o); end
    @(posedge wb_clk_i); #1;
  endtask

  task automatic test_word_read;
    int rises0;
    rises0 = valid_rises;
    start_req(1'b0, 2'd2, 32'h0000_0040, 32'hFFFF_FFFF);
    n_cmp++; if (mem_wstrb !== 4'b0000) begin n_bad++; $display("FAIL rd_wstrb got %b want 0000", mem_wstrb); end
    n_cmp++; if (mem_addr !== 32'h40) begin n_bad++; $display("FAIL rd_addr got %h want 00000040", mem_addr); end
    for (int i = 0; i < 3; i++) begin
      @(posedge wb_clk_i); #1;
      n_cmp++; if (mem_valid !== 1'b1) begin n_bad++; $display("FAIL rd_wait%0d got %b want 1", i, mem_valid); end
    end
    pulse_ready(32'h1234_5678);
    n_cmp++; if (scr_resp_o !== 2'd1) begin n_bad++; $display("FAIL rd_rdy got %0d want 1", scr_resp_o); end
    n_cmp++; if (scr_rdata_o !== 32'h1234_5678) begin n_bad++; $display("FAIL rd_rdata got %h want 12345678", scr_rdata_o); end
    n_cmp++; if (mem_valid !== 1'b0) begin n_bad++; $display("FAIL rd_drop got %b want 0", mem_valid); end
    repeat (2) @(posedge wb_clk_i); #1;
    n_cmp++; if (valid_rises - rises0 !== 1) begin n_bad++; $display("FAIL rd_single got %0d valid rises want 1", valid_rises - rises0); end
    n_cmp++; if (scr_rdata_o !== 32'h1234_5678) begin n_bad++; $display("FAIL rd_hold got %h want 12345678", scr_rdata_o); end
  endtask

  task automatic test_stray_ready;
    pulse_ready(32'h5555_5555);
    n_cmp++; if (scr_resp_o !== 2'd0 || scr_rdata_o !== 32'h1234_5678)
      begin n_bad++; $display("FAIL stray resp=%0d rdata=%h want resp=0 rdata=12345678", scr_resp_o, scr_rdata_o); end
    n_cmp++; if (scr_req_ack_o !== 1'b1) begin n_bad++; $display("FAIL stray_ack got %b want 1", scr_req_ack_o); end
  endtask

  task automatic test_misaligned;
    logic [1:0]  w_tab [3] = '{2'd1, 2'd2, 2'd3};
    logic [31:0] a_tab [3] = '{32'h101, 32'h102, 32'h0};
    int rises0;
    rises0 = valid_rises;
    for (int i = 0; i < 3; i++) begin
      start_req(1'b1, w_tab[i], a_tab[i], 32'h0);
      n_cmp++; if (scr_resp_o !== 2'd2) begin n_bad++; $display("FAIL mis%0d_er got %0d want 2", i, scr_resp_o); end
      n_cmp++; if (mem_valid !== 1'b0) begin n_bad++; $display("FAIL mis%0d_valid got %b want 0", i, mem_valid); end
      @(posedge wb_clk_i); #1;
      n_cmp++; if (scr_resp_o !== 2'd0 || scr_req_ack_o !== 1'b1)
        begin n_bad++; $display("FAIL mis%0d_end resp=%0d ack=%b want 0/1", i, scr_resp_o, scr_req_ack_o); end
    end
    n_cmp++; if (valid_rises !== rises0) begin n_bad++; $display("FAIL mis_bus got %0d rises want 0", valid_rises - rises0); end
  endtask

  task automatic test_reset_mid_busy;
    start_req(1'b0, 2'd2, 32'h0000_0080, 32'h0);
    @(posedge wb_clk_i); #3;
    wb_rst_n_i = 1'b0;
    #1;
    n_cmp++; if (mem_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_valid got %b want 0", mem_valid); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL mrst_addr got %h want 0", mem_addr); end
    n_cmp++; if (scr_rdata_o !== 32'h0) begin n_bad++; $display("FAIL mrst_rdata got %h want 0", scr_rdata_o); end
    @(negedge wb_clk_i);
    wb_rst_n_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge wb_clk_i); #1;
      n_cmp++; if (scr_resp_o !== 2'd0 || mem_valid !== 1'b0)
        begin n_bad++; $display("FAIL mrst_quiet%0d resp=%0d valid=%b want 0/0", i, scr_resp_o, mem_valid); end
    end
    n_cmp++; if (scr_req_ack_o !== 1'b1) begin n_bad++; $display("FAIL mrst_ack got %b want 1", scr_req_ack_o); end
  endtask

  task automatic test_back_to_back;
    start_req(1'b1, 2'd0, 32'h0000_0001, 32'h0000_003C);
    n_cmp++; if (mem_wstrb !== 4'b0010 || mem_wdata !== 32'h3C3C_3C3C)
      begin n_bad++; $display("FAIL b2b_a strb=%b wdata=%h want 0010/3c3c3c3c", mem_wstrb, mem_wdata); end
    pulse_ready(32'h0000_0011);
    @(posedge wb_clk_i); #1;
    start_req(1'b1, 2'd1, 32'h0000_0010, 32'h0000_BEEF);
    n_cmp++; if (mem_valid !== 1'b1 || mem_wstrb !== 4'b0011 || mem_addr !== 32'h10)
      begin n_bad++; $display("FAIL b2b_b valid=%b strb=%b addr=%h want 1/0011/00000010", mem_valid, mem_wstrb, mem_addr); end
    pulse_ready(32'h0000_0022);
    n_cmp++; if (scr_resp_o !== 2'd1 || scr_rdata_o !== 32'h22)
      begin n_bad++; $display("FAIL b2b_rdy resp=%0d rdata=%h want 1/00000022", scr_resp_o, scr_rdata_o); end
    @(posedge wb_clk_i); #1;
  endtask

  initial begin
    test_reset;
    test_word_write;
    test_byte_half_write;
    test_word_read;
    test_stray_ready;
    test_misaligned;
    test_reset_mid_busy;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
